// File: rtl/secuenciador_pkg.sv
// Shared types and constants for the instruction sequencer. This includes the FSM
// state encoding, the default widths and the field layout of the datapath instruction.
package secuenciador_pkg;

  localparam int IW_DEF = 20;
  localparam int AW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } estado_e;

  // Field layout of the downstream datapath instruction word
  localparam int WE_B_BIT = 19;
  localparam int DL1_MSB  = 18;
  localparam int DL1_LSB  = 14;
  localparam int DL2_MSB  = 13;
  localparam int DL2_LSB  = 9;
  localparam int DE_MSB   = 8;
  localparam int DE_LSB   = 4;
  localparam int WE_A_BIT = 3;
  localparam int SEL_MSB  = 2;
  localparam int SEL_LSB  = 0;

endpackage

// File: rtl/secuenciador_instr_mem.sv
// Program memory for the sequencer. Writes are synchronous and reads are combinational,
// so the fetched word can be registered straight into the output stage.
module mem_instr #(
  parameter int IW = 20,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/secuenciador_instr.sv
// Streams program words from address 0 to a latched last address into the datapath.
// One word is issued per clock. While not issuing, the output word is all zero.
import secuenciador_pkg::*;

module secuenciador_instr #(
  parameter int IW = IW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic [AW-1:0] ultima,
  input  logic          start,
  input  logic          stop,
  output logic [IW-1:0] instruccion,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          ocupado,
  output logic          fin
);

  estado_e       estado_q, estado_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] ultima_q, ultima_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          ultimo_q, ultimo_d;
  logic          mem_we;
  logic [IW-1:0] mem_rdata;

  mem_instr #(
    .IW(IW),
    .AW(AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc_q),
    .rdata(mem_rdata)
  );

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    ultima_d = ultima_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    ultimo_d = ultimo_q;
    mem_we   = 1'b0;
    unique case (estado_q)
      IDLE: begin
        mem_we = prog_we;
        if (start && !stop) begin
          estado_d = RUN;
          pc_d     = '0;
          ultima_d = ultima;
          ultimo_d = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          estado_d = IDLE;
          instr_d  = '0;
          valid_d  = 1'b0;
          pc_d     = '0;
          ultimo_d = 1'b0;
        end else if (ultimo_q) begin
          // The final word has been on the bus for one cycle; retire it here
          estado_d = DONE;
          instr_d  = '0;
          valid_d  = 1'b0;
          ultimo_d = 1'b0;
        end else begin
          instr_d  = mem_rdata;
          valid_d  = 1'b1;
          pc_d     = pc_q + AW'(1);
          ultimo_d = (pc_q == ultima_q);
        end
      end
      DONE: begin
        mem_we = prog_we;
        if (stop) begin
          estado_d = IDLE;
        end else if (start) begin
          estado_d = RUN;
          pc_d     = '0;
          ultima_d = ultima;
          ultimo_d = 1'b0;
        end
      end
      default: begin
        estado_d = IDLE;
        instr_d  = '0;
        valid_d  = 1'b0;
        pc_d     = '0;
        ultimo_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= IDLE;
      pc_q     <= '0;
      ultima_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      ultimo_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      ultima_q <= ultima_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      ultimo_q <= ultimo_d;
    end
  end

  assign instruccion = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign ocupado     = (estado_q == RUN);
  assign fin         = (estado_q == DONE);

endmodule

// File: tb/tb_secuenciador_instr.sv
// Directed bench for secuenciador_instr. Each task drives one scenario and compares
// the outputs against hand-computed words and flags.
module tb_secuenciador_instr;

  localparam int IW = 20;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic [AW-1:0] ultima = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [IW-1:0] instruccion;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          ocupado;
  logic          fin;

  int n_vec = 0;
  int n_err = 0;

  secuenciador_instr #(.IW(IW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .ultima     (ultima),
    .start      (start),
    .stop       (stop),
    .instruccion(instruccion),
    .instr_valid(instr_valid),
    .pc         (pc),
    .ocupado    (ocupado),
    .fin        (fin)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [AW-1:0] a, input logic [IW-1:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({instruccion, instr_valid, pc, ocupado, fin} !== {20'h0, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got i=%h v=%b pc=%0d oc=%b fin=%b, want all 0",
               instruccion, instr_valid, pc, ocupado, fin);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_short_program();
    logic [IW-1:0] expw [3];
    expw[0] = 20'h0C218;
    expw[1] = 20'h84A39;
    expw[2] = 20'h00000;
    for (int i = 0; i < 3; i++) prog(AW'(i), expw[i]);
    ultima = 5'd2;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    n_vec++;
    if ({ocupado, instr_valid, fin, pc} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      n_err++;
      $display("FAIL short_accept: got oc=%b v=%b fin=%b pc=%0d, want oc=1 v=0 fin=0 pc=0",
               ocupado, instr_valid, fin, pc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({instr_valid, instruccion, ocupado} !== {1'b1, expw[i], 1'b1}) begin
        n_err++;
        $display("FAIL short_word%0d: got v=%b i=%h oc=%b, want v=1 i=%h oc=1",
                 i, instr_valid, instruccion, ocupado, expw[i]);
      end
    end
    tick();
    n_vec++;
    if ({instr_valid, instruccion, fin, ocupado} !== {1'b0, 20'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL short_done: got v=%b i=%h fin=%b oc=%b, want v=0 i=0 fin=1 oc=0",
               instr_valid, instruccion, fin, ocupado);
    end
  endtask

  task automatic test_stop_during_run();
    logic saw;
    for (int i = 0; i <= 10; i++) prog(AW'(i), 20'hA0000 + IW'(i));
    ultima = 5'd10;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({instr_valid, instruccion} !== {1'b1, 20'hA0000 + IW'(i)}) begin
        n_err++;
        $display("FAIL stop_word%0d: got v=%b i=%h, want v=1 i=%h",
                 i, instr_valid, instruccion, 20'hA0000 + IW'(i));
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_vec++;
    if ({instr_valid, instruccion, pc, ocupado, fin} !== {1'b0, 20'h0, 5'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL stop_idle: got v=%b i=%h pc=%0d oc=%b fin=%b, want v=0 i=0 pc=0 oc=0 fin=0",
               instr_valid, instruccion, pc, ocupado, fin);
    end
    saw = 1'b0;
    repeat (15) begin
      tick();
      if (fin || instr_valid || ocupado) saw = 1'b1;
    end
    n_vec++;
    if (saw !== 1'b0) begin
      n_err++;
      $display("FAIL stop_no_fin: got activity=%b after stop, want 0", saw);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 32; i++) prog(AW'(i), IW'(i));
    ultima = 5'd31;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      n_vec++;
      if ({instr_valid, instruccion} !== {1'b1, IW'(i)}) begin
        n_err++;
        $display("FAIL wrap_word%0d: got v=%b i=%h, want v=1 i=%h",
                 i, instr_valid, instruccion, IW'(i));
      end
    end
    n_vec++;
    if (pc !== 5'd0) begin
      n_err++;
      $display("FAIL wrap_pc: got pc=%0d, want 0", pc);
    end
    tick();
    n_vec++;
    if ({fin, instr_valid, instruccion} !== {1'b1, 1'b0, 20'h0}) begin
      n_err++;
      $display("FAIL wrap_done: got fin=%b v=%b i=%h, want fin=1 v=0 i=0",
               fin, instr_valid, instruccion);
    end
  endtask

  task automatic test_write_gating();
    ultima = 5'd3;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    prog_we   = 1'b1;
    prog_addr = 5'd1;
    prog_data = 20'hFFFFF;
    tick();
    prog_we   = 1'b0;
    tick();
    tick();
    tick();
    ultima = 5'd1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({instr_valid, instruccion} !== {1'b1, 20'h00001}) begin
      n_err++;
      $display("FAIL gate_mem1: got v=%b i=%h, want v=1 i=00001", instr_valid, instruccion);
    end
    tick();
    n_vec++;
    if (fin !== 1'b1) begin
      n_err++;
      $display("FAIL gate_done: got fin=%b, want 1", fin);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_vec++;
    if ({fin, ocupado} !== 2'b00) begin
      n_err++;
      $display("FAIL done_stop_idle: got fin=%b oc=%b, want 0 0", fin, ocupado);
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({ocupado, instr_valid, fin} !== 3'b000) begin
      n_err++;
      $display("FAIL start_stop_prio: got oc=%b v=%b fin=%b, want 0 0 0",
               ocupado, instr_valid, fin);
    end
    start = 1'b0;
    stop  = 1'b0;
    tick();
  endtask

  task automatic test_restart_from_done();
    ultima = 5'd0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    n_vec++;
    if (fin !== 1'b1) begin
      n_err++;
      $display("FAIL restart_pre_done: got fin=%b, want 1", fin);
    end
    prog(5'd0, 20'h12345);
    ultima = 5'd0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    n_vec++;
    if ({ocupado, fin} !== 2'b10) begin
      n_err++;
      $display("FAIL restart_accept: got oc=%b fin=%b, want 1 0", ocupado, fin);
    end
    tick();
    n_vec++;
    if ({instr_valid, instruccion} !== {1'b1, 20'h12345}) begin
      n_err++;
      $display("FAIL restart_word: got v=%b i=%h, want v=1 i=12345", instr_valid, instruccion);
    end
    tick();
    n_vec++;
    if ({fin, instr_valid, instruccion} !== {1'b1, 1'b0, 20'h0}) begin
      n_err++;
      $display("FAIL restart_done: got fin=%b v=%b i=%h, want fin=1 v=0 i=0",
               fin, instr_valid, instruccion);
    end
  endtask

  task automatic test_reset_midrun();
    logic saw;
    ultima = 5'd10;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    tick();
    n_vec++;
    if ({pc, instr_valid} !== {5'd3, 1'b1}) begin
      n_err++;
      $display("FAIL midrun_pc: got pc=%0d v=%b, want pc=3 v=1", pc, instr_valid);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({instruccion, instr_valid, pc, ocupado, fin} !== {20'h0, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL midrun_async: got i=%h v=%b pc=%0d oc=%b fin=%b, want all 0",
               instruccion, instr_valid, pc, ocupado, fin);
    end
    tick();
    rst = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      tick();
      if (instr_valid || ocupado || fin) saw = 1'b1;
    end
    n_vec++;
    if (saw !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_quiet: got activity=%b after reset, want 0", saw);
    end
  endtask

  initial begin
    test_reset();
    test_short_program();
    test_stop_during_run();
    test_wrap();
    test_write_gating();
    test_restart_from_done();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
